// File: rtl/tanh_pkg.sv
// Shared definitions for the tanh pipeline and its lane unpacker:
// sample width, Q5.11 constants, result-pair layout, serializer states.
package tanh_pkg;

  localparam int unsigned DATA_W = 16;

  // Q5.11: 11 fractional bits, so 1.0 is 2^11.
  localparam logic signed [DATA_W-1:0] ONE     = 16'sd2048;
  localparam logic signed [DATA_W-1:0] NEG_ONE = -16'sd2048;

  typedef struct packed {
    logic [DATA_W-1:0] y1;
    logic [DATA_W-1:0] y0;
  } tanh_pair_t;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } ser_state_e;

endpackage

// File: rtl/tanh_pair_fifo.sv
// Pair FIFO for the lane unpacker: storage, wrapping pointers, occupancy.
// A push while full is accepted only when a pop happens in the same cycle;
// otherwise it is reported on 'dropped' and the pair is discarded.
module tanh_pair_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [CNT_W-1:0] occ,
  output logic             empty,
  output logic             dropped
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             full;
  logic             push_ok;
  logic             pop_ok;

  // Accept/drop decisions and next pointer/occupancy values.
  always_comb begin
    empty   = (occ_q == '0);
    full    = (occ_q == CNT_W'(DEPTH));
    pop_ok  = pop && !empty;
    push_ok = push && (!full || pop_ok);
    dropped = push && !push_ok;

    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    occ_d = occ_q;
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase

    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = wdata;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage is left uninitialised; readers gate it with 'empty'.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign occ   = occ_q;

endmodule

// File: rtl/tanh_lane_unpacker.sv
// Serializes 2-lane tanh result pairs onto a single-lane valid/ready
// stream (lane 0 first) and issues credits to the upstream feeder.
// Optional macro TANH_UNPACK_OVF_CNT_EN adds an 8-bit saturating ovf_cnt
// output counting dropped pairs plus credit violations.
module tanh_lane_unpacker #(
  parameter int unsigned DATA_W = tanh_pkg::DATA_W,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_in,
  input  logic [DATA_W-1:0] y0_in,
  input  logic [DATA_W-1:0] y1_in,
  input  logic              pair_valid_in,
  output logic              credit_ok,
  output logic [DATA_W-1:0] m_data,
  output logic              m_lane,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              ovf_flag,
`ifdef TANH_UNPACK_OVF_CNT_EN
  output logic [7:0]        ovf_cnt,
`endif
  input  logic              clear_ovf
);

  import tanh_pkg::ser_state_e;
  import tanh_pkg::LANE0;
  import tanh_pkg::LANE1;

  ser_state_e         state_q, state_d;
  logic [CNT_W-1:0]   infl_q, infl_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   occ;
  logic [CNT_W:0]     occ_sum;
  logic [2*DATA_W-1:0] head;
  logic               empty;
  logic               dropped;
  logic               pop;
  logic               violation;

  tanh_pair_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (pair_valid_in),
    .pop     (pop),
    .wdata   ({y1_in, y0_in}),
    .rdata   (head),
    .occ     (occ),
    .empty   (empty),
    .dropped (dropped)
  );

  // Credit from registered occupancy and in-flight count only.
  always_comb begin
    occ_sum   = {1'b0, occ} + {1'b0, infl_q};
    credit_ok = (occ_sum < (CNT_W + 1)'(DEPTH));
    violation = issue_in && !credit_ok;
  end

  // In-flight tracking: issue adds, returning pair removes, saturating.
  always_comb begin
    infl_d = infl_q;
    if (issue_in && !pair_valid_in && (infl_q != CNT_W'(DEPTH)))
      infl_d = infl_q + CNT_W'(1);
    else if (!issue_in && pair_valid_in && (infl_q != '0))
      infl_d = infl_q - CNT_W'(1);
  end

  // Sticky error flag; a new error wins over a same-cycle clear.
  always_comb begin
    ovf_d = ovf_q;
    if (dropped || violation) ovf_d = 1'b1;
    else if (clear_ovf)       ovf_d = 1'b0;
  end

  // Serializer state, in-flight counter and flag registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LANE0;
      infl_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      infl_q  <= infl_d;
      ovf_q   <= ovf_d;
    end
  end

  // Serializer next state: lane 0 beat moves to lane 1, lane 1 beat pops.
  always_comb begin
    state_d = state_q;
    if (m_valid && m_ready) begin
      case (state_q)
        LANE0:   state_d = LANE1;
        LANE1:   state_d = LANE0;
        default: state_d = LANE0;
      endcase
    end
  end

  // Serializer outputs; data forced to zero while the FIFO is empty.
  always_comb begin
    m_valid = !empty;
    m_lane  = (state_q == LANE1);
    m_data  = '0;
    if (!empty) m_data = (state_q == LANE1) ? head[2*DATA_W-1:DATA_W] : head[DATA_W-1:0];
    pop     = (state_q == LANE1) && m_valid && m_ready;
  end

  assign fifo_count = occ;
  assign ovf_flag   = ovf_q;

`ifdef TANH_UNPACK_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  logic [8:0] cnt_sum;

  // Saturating error count; both error kinds can land in one cycle.
  always_comb begin
    cnt_sum   = {1'b0, (clear_ovf ? 8'd0 : ovf_cnt_q)} + {8'd0, dropped} + {8'd0, violation};
    ovf_cnt_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // Error count register.
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_cnt_q <= '0;
    else        ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_tanh_lane_unpacker.sv
// Scoreboard bench for tanh_lane_unpacker: stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_tanh_lane_unpacker;

  localparam int DW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          issue_in;
  logic [DW-1:0] y0_in, y1_in;
  logic          pair_valid_in;
  logic          credit_ok;
  logic [DW-1:0] m_data;
  logic          m_lane;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] fifo_count;
  logic          ovf_flag;
  logic          clear_ovf;

  always #5 clk = ~clk;

  tanh_lane_unpacker #(.DATA_W(16), .DEPTH(8), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_in      (issue_in),
    .y0_in         (y0_in),
    .y1_in         (y1_in),
    .pair_valid_in (pair_valid_in),
    .credit_ok     (credit_ok),
    .m_data        (m_data),
    .m_lane        (m_lane),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .fifo_count    (fifo_count),
    .ovf_flag      (ovf_flag),
    .clear_ovf     (clear_ovf)
  );

  typedef struct {
    logic          lane;
    logic [DW-1:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    tests = 0;
  int    fails = 0;
  int    beats = 0;

  // Model of the 3-cycle tanh pipeline return path.
  logic          pv_pipe [2];
  logic [DW-1:0] p0_pipe [2];
  logic [DW-1:0] p1_pipe [2];
  logic [DW-1:0] iss_y0, iss_y1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_pair(input logic [DW-1:0] a, input logic [DW-1:0] b);
    beat_t e;
    e.lane = 1'b0; e.data = a; sb.push_back(e);
    e.lane = 1'b1; e.data = b; sb.push_back(e);
  endtask

  task automatic tick();
    logic          ni;
    logic [DW-1:0] a, b;
    ni = issue_in; a = iss_y0; b = iss_y1;
    @(posedge clk);
    #1;
    issue_in      = 1'b0;
    clear_ovf     = 1'b0;
    pair_valid_in = pv_pipe[1];
    y0_in         = p0_pipe[1];
    y1_in         = p1_pipe[1];
    if (pv_pipe[1]) expect_pair(p0_pipe[1], p1_pipe[1]);
    pv_pipe[1] = pv_pipe[0]; p0_pipe[1] = p0_pipe[0]; p1_pipe[1] = p1_pipe[0];
    pv_pipe[0] = ni;         p0_pipe[0] = a;          p1_pipe[0] = b;
  endtask

  task automatic force_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit store);
    pair_valid_in = 1'b1;
    y0_in = a;
    y1_in = b;
    if (store) expect_pair(a, b);
  endtask

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b);
    issue_in = 1'b1;
    iss_y0 = a;
    iss_y1 = b;
  endtask

  // Monitor: every accepted beat must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
      beats++;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL beat_unexpected: got lane %0d data 0x%0h, expected no beat", m_lane, m_data);
      end else begin
        mon_e = sb.pop_front();
        if (m_lane !== mon_e.lane || m_data !== mon_e.data) begin
          fails++;
          $display("FAIL beat: got lane %0d data 0x%0h, expected lane %0d data 0x%0h",
                   m_lane, m_data, mon_e.lane, mon_e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int b0;
    rst_n = 1'b0; issue_in = 1'b0; y0_in = '0; y1_in = '0;
    pair_valid_in = 1'b0; m_ready = 1'b0; clear_ovf = 1'b0;
    iss_y0 = '0; iss_y1 = '0;
    for (int i = 0; i < 2; i++) begin
      pv_pipe[i] = 1'b0; p0_pipe[i] = '0; p1_pipe[i] = '0;
    end

    // Reset
    tick(); tick();
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_lane", 32'(m_lane), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_credit_ok", 32'(credit_ok), 32'd1);
    chk("rst_ovf_flag", 32'(ovf_flag), 32'd0);
    rst_n = 1'b1;

    // Single pair, sink always ready
    m_ready = 1'b1;
    force_pair(16'h0618, 16'hF9E8, 1'b1);
    tick();
    chk("single_l0_valid", 32'(m_valid), 32'd1);
    chk("single_l0_lane", 32'(m_lane), 32'd0);
    chk("single_l0_data", 32'(m_data), 32'h0618);
    tick();
    chk("single_l1_lane", 32'(m_lane), 32'd1);
    chk("single_l1_data", 32'(m_data), 32'hF9E8);
    tick();
    chk("single_count", 32'(fifo_count), 32'd0);
    chk("single_empty_valid", 32'(m_valid), 32'd0);
    chk("single_empty_data", 32'(m_data), 32'd0);

    // Credit and backpressure: 8 issues, 3-cycle return
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("credit_before_issue", 32'(credit_ok), 32'd1);
      issue(16'(16'h0100 + i), 16'(16'hFF00 - i));
      tick();
    end
    chk("credit_after_8", 32'(credit_ok), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("credit_full_count", 32'(fifo_count), 32'd8);
    chk("credit_full_credit", 32'(credit_ok), 32'd0);
    b0 = beats;
    m_ready = 1'b1;
    tick(); tick();
    chk("credit_after_pop", 32'(credit_ok), 32'd1);
    chk("count_after_pop", 32'(fifo_count), 32'd7);
    for (int n = 0; n < 40 && fifo_count != 0; n++) tick();
    chk("drain_count", 32'(fifo_count), 32'd0);
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_beats", 32'(beats - b0), 32'd16);

    // Overflow at full with no pop
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      force_pair(16'(16'h0A00 + i), 16'(16'h0B00 + i), 1'b1);
      tick();
    end
    force_pair(16'hDEAD, 16'hBEEF, 1'b0);
    tick();
    chk("ovf_count", 32'(fifo_count), 32'd8);
    chk("ovf_flag_set", 32'(ovf_flag), 32'd1);
    chk("ovf_credit", 32'(credit_ok), 32'd0);
    clear_ovf = 1'b1;
    tick();
    chk("ovf_cleared", 32'(ovf_flag), 32'd0);

    // Push at full on the lane-1 pop cycle, plus a credit violation
    m_ready = 1'b1;
    tick();
    chk("pushpop_lane1", 32'(m_lane), 32'd1);
    issue(16'h1234, 16'h5678);
    force_pair(16'h7FFF, 16'h8000, 1'b1);
    tick();
    chk("pushpop_count", 32'(fifo_count), 32'd8);
    chk("pushpop_violation", 32'(ovf_flag), 32'd1);
    for (int n = 0; n < 60 && (fifo_count != 0 || sb.size() != 0); n++) tick();
    chk("pushpop_drain_count", 32'(fifo_count), 32'd0);
    chk("pushpop_sb_empty", 32'(sb.size()), 32'd0);
    chk("pushpop_credit", 32'(credit_ok), 32'd1);
    clear_ovf = 1'b1;
    tick();
    chk("pushpop_ovf_cleared", 32'(ovf_flag), 32'd0);

    // Reset mid-stream: 5 stored, 2 in flight
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      force_pair(16'(16'h0C00 + i), 16'(16'h0D00 + i), 1'b0);
      tick();
    end
    issue(16'h0E01, 16'h0F01);
    tick();
    issue(16'h0E02, 16'h0F02);
    tick();
    chk("mid_count", 32'(fifo_count), 32'd5);
    chk("mid_credit", 32'(credit_ok), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_credit", 32'(credit_ok), 32'd1);
    m_ready = 1'b1;
    b0 = beats;
    for (int i = 0; i < 12; i++) tick();
    chk("mid_after_count", 32'(fifo_count), 32'd0);
    chk("mid_after_sb", 32'(sb.size()), 32'd0);
    chk("mid_after_beats", 32'(beats - b0), 32'd4);
    chk("mid_after_credit", 32'(credit_ok), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tanh_lane_unpacker.md
# tanh_lane_unpacker

Downstream companion of the 2-lane Q5.11 tanh pipeline. It captures every result pair the pipeline produces into a small pair FIFO and serializes it onto a single-lane valid/ready stream, lane 0 first. The tanh pipeline cannot stall, so the block also issues an issue-credit to the upstream feeder. The credit tracks FIFO occupancy plus pairs still in flight, so no result is ever dropped when the feeder honours it.

## Interface
- DATA_W, 16: sample width, Q5.11 signed.
- DEPTH, 8: FIFO depth in pairs; power of two, ≥ 2.
- CNT_W, $clog2(DEPTH)+1: width of occupancy and in-flight counters.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- issue_in  in  1  high in the cycle a pair enters the tanh pipeline (the pipeline's valid_in).
- y0_in  in  DATA_W  lane-0 result (pipeline y0_out).
- y1_in  in  DATA_W  lane-1 result (pipeline y1_out).
- pair_valid_in  in  1  result pair valid (pipeline valid_out).
- credit_ok  out  1  feeder may assert issue_in this cycle.
- m_data  out  DATA_W  serialized sample.
- m_lane  out  1  source lane of m_data (0 or 1).
- m_valid  out  1  m_data valid.
- m_ready  in  1  sink accepts.
- fifo_count  out  CNT_W  pairs stored.
- ovf_flag  out  1  sticky error flag.
- clear_ovf  in  1  clears ovf_flag.

## Operation
- Occupancy counter occ: 0..DEPTH. In-flight counter infl: 0..DEPTH.
- infl update: +1 on issue_in, −1 on pair_valid_in; both in the same cycle leaves it unchanged. Saturates at 0 and DEPTH.
- credit_ok = (occ + infl) < DEPTH; combinational from registers only.
- issue_in while credit_ok=0 is a credit violation: ovf_flag is set and infl still increments (saturating).
- Push: pair_valid_in writes {y1_in,y0_in} at the write pointer.
  - Push while occ==DEPTH with no pop in the same cycle: the pair is dropped and ovf_flag is set.
  - Push at full with a pop in the same cycle: accepted, occ unchanged.
- Serializer FSM, states LANE0 and LANE1, reset state LANE0.
  - m_valid = (occ ≠ 0).
  - m_data is the head y0 in LANE0 and the head y1 in LANE1. m_lane = (state==LANE1).
  - LANE0 with m_valid & m_ready → LANE1.
  - LANE1 with m_valid & m_ready → pop head, → LANE0.
  - No handshake: state holds, m_data stable.
- Pointers wrap modulo DEPTH.
- ovf_flag: set has priority over clear_ovf in the same cycle.

## Timing
- Reset (rst_n low at an edge) clears occ, infl, pointers, FSM→LANE0, ovf_flag.
  - Output values after reset: m_valid=0, m_lane=0, m_data=0 (storage need not be cleared; m_data is forced to 0 while empty), fifo_count=0, credit_ok=1.
- Reset mid-stream discards stored and in-flight pairs. Results arriving after reset are treated as new pushes.
- Latency: pair_valid_in at edge t → m_valid=1 with lane-0 data in cycle t+1; lane 1 is presented no earlier than t+2.
- Throughput: one sample per cycle with m_ready held high, i.e. one pair per two cycles. The feeder must issue at ≤ one pair per two cycles on average to avoid credit stall.
- credit_ok reflects an issue_in in cycle t from cycle t+1 onward.

## Configuration
- TANH_UNPACK_OVF_CNT_EN defined:
  - adds output ovf_cnt [7:0], a saturating count of dropped pairs plus credit violations;
  - clear_ovf also clears ovf_cnt;
  - reset value 0.
- Undefined: no ovf_cnt port; only the sticky ovf_flag.

## Structure
- Shared package tanh_pkg:
  - DATA_W;
  - Q5.11 constants (ONE = 16'sd2048);
  - packed pair typedef tanh_pair_t {y1, y0};
  - serializer state enum.
- Sub-module tanh_pair_fifo: storage, pointers, occ, full/empty, simultaneous push/pop. The top level holds infl, credit, FSM and flags.

## Test plan
- Reset: hold rst_n=0 for 2 edges → m_valid=0, fifo_count=0, credit_ok=1, ovf_flag=0.
- Single pair y0=0x0618, y1=0xF9E8, m_ready=1:
  - lane-0 beat (0x0618, m_lane=0) one cycle after the push;
  - lane-1 beat (0xF9E8, m_lane=1) the following cycle;
  - fifo_count returns to 0.
- Credit and backpressure: m_ready=0, issue 8 pairs with 3-cycle return.
  - credit_ok=0 from the cycle after the 8th issue_in; fifo_count=8.
  - Raise m_ready → 16 beats in order, alternating lanes; credit_ok=1 after the first pop.
- Overflow: at full with m_ready=0, force pair_valid_in → pair dropped, ovf_flag=1, fifo_count stays 8. Pulse clear_ovf → ovf_flag=0 next cycle.
- Push at full on the LANE1 pop cycle → accepted, fifo_count stays 8, data order preserved; credit violation sets ovf_flag.
- Reset mid-stream with occ=5 and 2 pairs in flight → all counters 0. Pairs returning after reset are stored and serialized normally.
